inmux_dat_5_2: RTL and testbench
================================

INMUX_DAT_5_2 -- requirements
Module: inmux_dat_5_2

Interface
Parameters:
REQ-001 SHALL have parameter DW, default 512, width of every data bus.

Ports (name  direction  width  meaning):
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have, for each N in {8, 9, 13, 14, 15}, port i_kN_dat  input  DW  source N data.
REQ-005 SHALL have, for each N, port i_kN_vld  input  1  source N beat valid.
REQ-006 SHALL have, for each N, port i_kN_last  input  1  source N final beat of burst.
REQ-007 SHALL have, for each N, port i_kN_rdy  output  1  source N beat accepted.
REQ-008 SHALL have port t_inmux_dat  output  DW  merged data.
REQ-009 SHALL have port t_inmux_vld  output  1  merged beat valid.
REQ-010 SHALL have port t_inmux_last  output  1  merged final beat of burst.
REQ-011 SHALL have port t_inmux_rdy  input  1  downstream ready.
REQ-012 SHALL have port t_c_dat  output  4  source tag of the current output beat, equal to N (4'd8, 4'd9, 4'd13, 4'd14, 4'd15).

Function
REQ-013 SHALL transfer a beat on any handshake only when vld=1 and rdy=1 in the same cycle.
REQ-014 SHALL hold one output register (dat, last, tag, vld); "load" = (!t_inmux_vld | t_inmux_rdy) and a granted source is valid.
REQ-015 SHALL drive i_kN_rdy=1 combinationally only for the granted source, and only when (!t_inmux_vld | t_inmux_rdy); all other rdy=0.
REQ-016 SHALL present a source beat on t_inmux_* exactly 1 cycle after its i_kN handshake (latency 1); back-to-back beats at full throughput when t_inmux_rdy=1.
REQ-017 SHALL keep t_inmux_dat, t_inmux_last and t_c_dat stable while t_inmux_vld=1 and t_inmux_rdy=0.
REQ-018 SHALL run an FSM with states IDLE and LOCK.
REQ-019 IDLE: SHALL pick a winner among valid sources by round-robin over ring 8->9->13->14->15->8, starting at the entry after the last granted source.
REQ-020 IDLE->LOCK: SHALL transition when the winner's first beat is accepted with last=0; the grant is held on that source.
REQ-021 IDLE: an accepted beat with last=1 SHALL complete the burst in one beat; the FSM stays in IDLE and the pointer advances.
REQ-022 LOCK: SHALL grant only the locked source; other sources' vld SHALL be ignored, including while the locked source has vld=0.
REQ-023 LOCK->IDLE: SHALL transition on acceptance of the locked source's beat with last=1; the round-robin pointer SHALL be updated to the locked source.
REQ-024 SHALL NOT change the winner in a cycle in which no handshake occurs.
REQ-025 Simultaneous events: output drain and new load in the same cycle SHALL both occur, with the new beat replacing the old one.
REQ-026 No valid source: t_inmux_vld SHALL deassert after drain; the FSM SHALL remain in its current state.

Reset
REQ-027 On reset_n=0, SHALL immediately force t_inmux_vld=0, t_inmux_last=0, t_c_dat=4'd0, t_inmux_dat=0, FSM=IDLE, and pointer so that k8 has highest priority.
REQ-028 SHALL force all i_kN_rdy=0 while reset_n=0.
REQ-029 On reset mid-burst, SHALL drop the lock and in-flight beat; no partial-burst recovery SHALL be performed.
REQ-030 SHALL resume arbitration on the first rising clk edge after reset_n deasserts.

Verification
REQ-031 Bench SHALL cover: single source k13, 1 beat, dat=0xA5.., last=1, t_inmux_rdy=1 -> next cycle t_inmux_vld=1, dat=0xA5.., t_c_dat=4'd13, last=1.
REQ-032 Bench SHALL cover: all five sources valid continuously with last=1, rdy=1 -> t_c_dat sequence 8, 9, 13, 14, 15, 8.
REQ-033 Bench SHALL cover: k9 sends a 4-beat burst while k14 is valid throughout -> four k9 beats contiguous with tag 9, then k14 beats.
REQ-034 Bench SHALL cover: t_inmux_rdy=0 for 5 cycles with the output valid -> output held constant, all i_kN_rdy=0, no beat lost or duplicated.
REQ-035 Bench SHALL cover: reset_n pulsed low mid-burst on k15 -> t_inmux_vld=0 asynchronously; after release with k8 and k15 valid, k8 wins first.
REQ-036 Bench SHALL cover: in LOCK, locked source vld gaps of 3 cycles while others are valid -> no other source granted until the last beat.

Source files
------------

// File: rtl/inmux_dat_5_2.sv
// Five-source input mux with burst locking and round-robin arbitration.
// Sources k8, k9, k13, k14 and k15 share one registered output stage. A
// multi-beat burst keeps the grant on its source until the beat marked last.
module inmux_dat_5_2 #(
    parameter int DW = 512
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [DW-1:0] i_k8_dat,
    input  logic          i_k8_vld,
    input  logic          i_k8_last,
    output logic          i_k8_rdy,
    input  logic [DW-1:0] i_k9_dat,
    input  logic          i_k9_vld,
    input  logic          i_k9_last,
    output logic          i_k9_rdy,
    input  logic [DW-1:0] i_k13_dat,
    input  logic          i_k13_vld,
    input  logic          i_k13_last,
    output logic          i_k13_rdy,
    input  logic [DW-1:0] i_k14_dat,
    input  logic          i_k14_vld,
    input  logic          i_k14_last,
    output logic          i_k14_rdy,
    input  logic [DW-1:0] i_k15_dat,
    input  logic          i_k15_vld,
    input  logic          i_k15_last,
    output logic          i_k15_rdy,
    output logic [DW-1:0] t_inmux_dat,
    output logic          t_inmux_vld,
    output logic          t_inmux_last,
    input  logic          t_inmux_rdy,
    output logic [3:0]    t_c_dat
);

    typedef enum logic {IDLE, LOCK} state_t;

    // Ring position 0..4 maps to sources k8, k9, k13, k14, k15.
    function automatic logic [2:0] ring_next(input logic [2:0] idx);
        case (idx)
            3'd0:    ring_next = 3'd1;
            3'd1:    ring_next = 3'd2;
            3'd2:    ring_next = 3'd3;
            3'd3:    ring_next = 3'd4;
            default: ring_next = 3'd0;
        endcase
    endfunction

    function automatic logic [3:0] tag_of(input logic [2:0] idx);
        case (idx)
            3'd0:    tag_of = 4'd8;
            3'd1:    tag_of = 4'd9;
            3'd2:    tag_of = 4'd13;
            3'd3:    tag_of = 4'd14;
            default: tag_of = 4'd15;
        endcase
    endfunction

    logic [DW-1:0] src_dat [5];
    logic [4:0]    src_vld;
    logic [4:0]    src_last;
    logic [4:0]    src_rdy;

    assign src_dat[0] = i_k8_dat;
    assign src_dat[1] = i_k9_dat;
    assign src_dat[2] = i_k13_dat;
    assign src_dat[3] = i_k14_dat;
    assign src_dat[4] = i_k15_dat;
    assign src_vld    = {i_k15_vld, i_k14_vld, i_k13_vld, i_k9_vld, i_k8_vld};
    assign src_last   = {i_k15_last, i_k14_last, i_k13_last, i_k9_last, i_k8_last};
    assign i_k8_rdy   = src_rdy[0];
    assign i_k9_rdy   = src_rdy[1];
    assign i_k13_rdy  = src_rdy[2];
    assign i_k14_rdy  = src_rdy[3];
    assign i_k15_rdy  = src_rdy[4];

    state_t        state, state_d;
    logic [2:0]    lock_idx, lock_idx_d;
    logic [2:0]    ptr, ptr_d;      // last granted ring position

    logic [DW-1:0] dat_p1;
    logic          last_p1;
    logic [3:0]    tag_p1;
    logic          vld_p1;

    logic [2:0]    rr_idx;
    logic          rr_hit;
    logic [2:0]    cand;
    logic [2:0]    gnt_idx;
    logic          gnt_vld;
    logic          can_load;
    logic          load;
    logic          gnt_last;

    // Round-robin search starting one position after the last granted source.
    always_comb begin
        rr_idx = 3'd0;
        rr_hit = 1'b0;
        cand   = ptr;
        for (int i = 0; i < 5; i++) begin
            cand = ring_next(cand);
            if (!rr_hit && src_vld[cand]) begin
                rr_hit = 1'b1;
                rr_idx = cand;
            end
        end
    end

    // Grant selection: locked source only while a burst is open.
    always_comb begin
        gnt_idx = rr_idx;
        gnt_vld = rr_hit;
        if (state == LOCK) begin
            gnt_idx = lock_idx;
            gnt_vld = src_vld[lock_idx];
        end
    end

    assign can_load = !vld_p1 || t_inmux_rdy;
    assign load     = can_load && gnt_vld;
    assign gnt_last = src_last[gnt_idx];

    // Ready goes only to the granted source, and never while in reset.
    always_comb begin
        src_rdy = 5'b00000;
        if (reset_n && can_load && gnt_vld)
            src_rdy[gnt_idx] = 1'b1;
    end

    // Burst FSM and round-robin pointer next-state.
    always_comb begin
        state_d    = state;
        lock_idx_d = lock_idx;
        ptr_d      = ptr;
        case (state)
            IDLE: begin
                if (load) begin
                    if (gnt_last) begin
                        ptr_d = gnt_idx;
                    end else begin
                        state_d    = LOCK;
                        lock_idx_d = gnt_idx;
                    end
                end
            end
            LOCK: begin
                if (load && gnt_last) begin
                    state_d = IDLE;
                    ptr_d   = lock_idx;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register; reset leaves k8 as highest priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            lock_idx <= 3'd0;
            ptr      <= 3'd4;
        end else begin
            state    <= state_d;
            lock_idx <= lock_idx_d;
            ptr      <= ptr_d;
        end
    end

    // Output stage: a new beat replaces the draining one, otherwise drain clears valid.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vld_p1  <= 1'b0;
            dat_p1  <= '0;
            last_p1 <= 1'b0;
            tag_p1  <= 4'd0;
        end else if (load) begin
            vld_p1  <= 1'b1;
            dat_p1  <= src_dat[gnt_idx];
            last_p1 <= gnt_last;
            tag_p1  <= tag_of(gnt_idx);
        end else if (t_inmux_rdy) begin
            vld_p1  <= 1'b0;
        end
    end

    assign t_inmux_dat  = dat_p1;
    assign t_inmux_vld  = vld_p1;
    assign t_inmux_last = last_p1;
    assign t_c_dat      = tag_p1;

endmodule

// File: tb/tb_inmux_dat_5_2.sv
// Directed bench for inmux_dat_5_2: cycle-by-cycle vector table plus a
// hand-written mid-burst reset sequence.
module tb_inmux_dat_5_2;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [4:0]    vld = 5'b0;
    logic [4:0]    last = 5'b0;
    logic [7:0]    b = 8'h00;
    logic          trdy = 1'b0;

    logic [DW-1:0] t_inmux_dat;
    logic          t_inmux_vld;
    logic          t_inmux_last;
    logic [3:0]    t_c_dat;
    logic          r8, r9, r13, r14, r15;
    logic [4:0]    rdy;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] mkdat(input logic [7:0] bb, input logic [3:0] tag);
        mkdat = {{(DW/8-1){bb}}, 4'h0, tag};
    endfunction

    assign rdy = {r15, r14, r13, r9, r8};

    inmux_dat_5_2 #(.DW(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .i_k8_dat(mkdat(b, 4'd8)),   .i_k8_vld(vld[0]),  .i_k8_last(last[0]),  .i_k8_rdy(r8),
        .i_k9_dat(mkdat(b, 4'd9)),   .i_k9_vld(vld[1]),  .i_k9_last(last[1]),  .i_k9_rdy(r9),
        .i_k13_dat(mkdat(b, 4'd13)), .i_k13_vld(vld[2]), .i_k13_last(last[2]), .i_k13_rdy(r13),
        .i_k14_dat(mkdat(b, 4'd14)), .i_k14_vld(vld[3]), .i_k14_last(last[3]), .i_k14_rdy(r14),
        .i_k15_dat(mkdat(b, 4'd15)), .i_k15_vld(vld[4]), .i_k15_last(last[4]), .i_k15_rdy(r15),
        .t_inmux_dat(t_inmux_dat), .t_inmux_vld(t_inmux_vld),
        .t_inmux_last(t_inmux_last), .t_inmux_rdy(trdy), .t_c_dat(t_c_dat)
    );

    typedef struct {
        logic [4:0] vld;
        logic [4:0] last;
        logic [7:0] b;
        logic       trdy;
        logic [4:0] erdy;
        logic       evld;
        logic [3:0] etag;
        logic       elast;
        logic [7:0] eb;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [4:0] v, input logic [4:0] l, input logic [7:0] bb,
                       input logic tr, input logic [4:0] er, input logic ev,
                       input logic [3:0] et, input logic el, input logic [7:0] eb);
        vec_t r;
        r.vld = v; r.last = l; r.b = bb; r.trdy = tr; r.erdy = er;
        r.evld = ev; r.etag = et; r.elast = el; r.eb = eb;
        tbl.push_back(r);
    endtask

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    initial begin
        // Round robin, all five valid single-beat bursts.
        add(5'b11111, 5'b11111, 8'h10, 1, 5'b00001, 1, 4'd8,  1, 8'h10);
        add(5'b11111, 5'b11111, 8'h11, 1, 5'b00010, 1, 4'd9,  1, 8'h11);
        add(5'b11111, 5'b11111, 8'h12, 1, 5'b00100, 1, 4'd13, 1, 8'h12);
        add(5'b11111, 5'b11111, 8'h13, 1, 5'b01000, 1, 4'd14, 1, 8'h13);
        add(5'b11111, 5'b11111, 8'h14, 1, 5'b10000, 1, 4'd15, 1, 8'h14);
        add(5'b11111, 5'b11111, 8'h15, 1, 5'b00001, 1, 4'd8,  1, 8'h15);
        add(5'b00000, 5'b00000, 8'h00, 1, 5'b00000, 0, 4'd0,  0, 8'h00);
        // k9 four-beat burst with k14 valid throughout.
        add(5'b01010, 5'b00000, 8'h20, 1, 5'b00010, 1, 4'd9,  0, 8'h20);
        add(5'b01010, 5'b00000, 8'h21, 1, 5'b00010, 1, 4'd9,  0, 8'h21);
        add(5'b01010, 5'b00000, 8'h22, 1, 5'b00010, 1, 4'd9,  0, 8'h22);
        add(5'b01010, 5'b00010, 8'h23, 1, 5'b00010, 1, 4'd9,  1, 8'h23);
        add(5'b01000, 5'b01000, 8'h24, 1, 5'b01000, 1, 4'd14, 1, 8'h24);
        add(5'b00000, 5'b00000, 8'h00, 1, 5'b00000, 0, 4'd0,  0, 8'h00);
        // Single k13 beat.
        add(5'b00100, 5'b11111, 8'hA5, 1, 5'b00100, 1, 4'd13, 1, 8'hA5);
        add(5'b00000, 5'b00000, 8'h00, 1, 5'b00000, 0, 4'd0,  0, 8'h00);
        // Downstream stall for five cycles with the output valid.
        add(5'b00001, 5'b11111, 8'h30, 0, 5'b00001, 1, 4'd8,  1, 8'h30);
        for (int i = 0; i < 5; i++)
            add(5'b00011, 5'b11111, 8'h31, 0, 5'b00000, 1, 4'd8, 1, 8'h30);
        add(5'b00011, 5'b11111, 8'h32, 1, 5'b00010, 1, 4'd9,  1, 8'h32);
        add(5'b00001, 5'b11111, 8'h33, 1, 5'b00001, 1, 4'd8,  1, 8'h33);
        add(5'b00000, 5'b00000, 8'h00, 1, 5'b00000, 0, 4'd0,  0, 8'h00);
        // Locked k13 burst with 3-cycle valid gap while others are valid.
        add(5'b00100, 5'b00000, 8'h40, 1, 5'b00100, 1, 4'd13, 0, 8'h40);
        for (int i = 0; i < 3; i++)
            add(5'b11011, 5'b11111, 8'h41, 1, 5'b00000, 0, 4'd0, 0, 8'h00);
        add(5'b11111, 5'b11011, 8'h42, 1, 5'b00100, 1, 4'd13, 0, 8'h42);
        add(5'b11111, 5'b11111, 8'h43, 1, 5'b00100, 1, 4'd13, 1, 8'h43);
        add(5'b11111, 5'b11111, 8'h44, 1, 5'b01000, 1, 4'd14, 1, 8'h44);
        add(5'b00000, 5'b00000, 8'h00, 1, 5'b00000, 0, 4'd0,  0, 8'h00);

        // Reset state with sources requesting.
        vld = 5'b11111; last = 5'b11111; trdy = 1;
        #12;
        chk("rst_vld",  t_inmux_vld, 0);
        chk("rst_last", t_inmux_last, 0);
        chk("rst_tag",  t_c_dat, 0);
        chk("rst_dat",  t_inmux_dat, 0);
        chk("rst_rdy",  rdy, 0);
        @(negedge clk);
        reset_n = 1;

        foreach (tbl[k]) begin
            vec_t r;
            r = tbl[k];
            if (k != 0) @(negedge clk);
            vld = r.vld; last = r.last; b = r.b; trdy = r.trdy;
            #1;
            chk($sformatf("v%0d_rdy", k), rdy, r.erdy);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_vld", k), t_inmux_vld, r.evld);
            if (r.evld) begin
                chk($sformatf("v%0d_tag", k), t_c_dat, r.etag);
                chk($sformatf("v%0d_last", k), t_inmux_last, r.elast);
                chk($sformatf("v%0d_dat", k), t_inmux_dat, mkdat(r.eb, r.etag));
            end
        end

        // Mid-burst reset on k15 (pointer now at k14, so k15 wins).
        @(negedge clk);
        vld = 5'b10000; last = 5'b00000; b = 8'h50; trdy = 1;
        @(posedge clk); #1;
        chk("k15_b0_tag", t_c_dat, 4'd15);
        chk("k15_b0_vld", t_inmux_vld, 1);
        @(negedge clk);
        b = 8'h51;
        @(posedge clk); #2;
        reset_n = 0;
        #1;
        chk("arst_vld",  t_inmux_vld, 0);
        chk("arst_tag",  t_c_dat, 0);
        chk("arst_dat",  t_inmux_dat, 0);
        chk("arst_last", t_inmux_last, 0);
        chk("arst_rdy",  rdy, 0);
        @(negedge clk);
        reset_n = 1;
        vld = 5'b10001; last = 5'b10001; b = 8'h60;
        #1;
        chk("post_rdy0", rdy, 5'b00001);
        @(posedge clk); #1;
        chk("post_tag0", t_c_dat, 4'd8);
        chk("post_vld0", t_inmux_vld, 1);
        chk("post_dat0", t_inmux_dat, mkdat(8'h60, 4'd8));
        @(negedge clk);
        b = 8'h61;
        #1;
        chk("post_rdy1", rdy, 5'b10000);
        @(posedge clk); #1;
        chk("post_tag1", t_c_dat, 4'd15);
        chk("post_last1", t_inmux_last, 1);
        @(negedge clk);
        vld = 5'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
